// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NCH-channel threshold FIFO bank with indexed registered read; VC_FIFO_OCC_EN adds an occupancy output
module vc_fifo_bank #(
   parameter int BW  = 6,
   parameter int NCH = 4,
   parameter int AW  = 2,
   parameter int SW  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    wr,
   input  logic [NCH*BW-1:0] data_in,
   input  logic              rd,
   input  logic [SW-1:0]     rd_sel,
   input  logic [AW:0]       umbral_bajo,
   input  logic [AW:0]       umbral_alto,
   input  logic [NCH-1:0]    error_clr,
   output logic [BW-1:0]     data_out,
   output logic              data_out_valid,
   output logic [NCH-1:0]    full,
   output logic [NCH-1:0]    empty,
   output logic [NCH-1:0]    almost_full,
   output logic [NCH-1:0]    almost_empty,
   output logic [NCH-1:0]    error
`ifdef VC_FIFO_OCC_EN
   ,
   output logic [NCH*(AW+1)-1:0] occupancy
`endif
);
   localparam int DEPTH = 2**AW;
   logic [NCH-1:0]    rd_hit;
   logic [NCH*BW-1:0] rd_word;
   logic              rd_ok;
   assign rd_ok = |rd_hit;
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [BW-1:0] mem [DEPTH];
      logic [AW-1:0] wp, rp;
      logic [AW:0]   cnt;
      logic          sel, wr_ok;
      assign sel                = rd && rd_sel == SW'(i);
      assign rd_hit[i]          = sel && !empty[i];
      assign wr_ok              = wr[i] && (!full[i] || rd_hit[i]);
      assign full[i]            = cnt == (AW+1)'(DEPTH);
      assign empty[i]           = cnt == '0;
      assign almost_full[i]     = cnt >= umbral_alto && umbral_alto != '0;
      assign almost_empty[i]    = cnt <= umbral_bajo;
      assign rd_word[i*BW +: BW] = mem[rp];
`ifdef VC_FIFO_OCC_EN
      assign occupancy[i*(AW+1) +: AW+1] = cnt;
`endif
      always_ff @(posedge clk)
         if (!reset && wr_ok) mem[wp] <= data_in[i*BW +: BW];
      always_ff @(posedge clk) begin
         if (reset) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            error[i] <= 1'b0;
         end else begin
            wp       <= wp + AW'(wr_ok);
            rp       <= rp + AW'(rd_hit[i]);
            cnt      <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_hit[i]);
            error[i] <= (error[i] && !error_clr[i]) || (wr[i] && !wr_ok) || (sel && empty[i]);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= rd_ok;
         data_out       <= rd_ok ? rd_word[int'(rd_sel)*BW +: BW] : data_out;
      end
   end
endmodule
